regfile_dumper: RTL and testbench

Sequential read-out engine for the 32×32-bit MIPS `RegisterFile`. On a `Start` pulse it drives the file's read address port over a programmable register range, one register per cycle. It captures each `ReadData` word and streams it out as (address, data) pairs on a valid/ready interface. It serves the debug/UART dump path and end-of-test register checks, and is the reading counterpart to the write port.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_dump_slot.sv | 34 +++
 rtl/regfile_dumper.sv | 88 ++++++++
 tb/tb_regfile_dumper.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and dumper state encoding
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } dumpState_t;
endpackage

// File: rtl/regfile_dump_slot.sv
// rtl/regfile_dump_slot.sv - one-entry (addr, data) output register with valid/ready handshake
module regfile_dump_slot
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] loadAddr,
   input  logic [DATA_W-1:0] loadData,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   // The word is only replaced on load, so a stalled word never picks up later file writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         addr  <= '0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         addr  <= loadAddr;
         data  <= loadData;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_dumper.sv
// rtl/regfile_dumper.sv - sequential read-out of a register range as (address, data) words
module regfile_dumper
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Start,
   input  logic [ADDR_W-1:0] FirstReg,
   input  logic [ADDR_W-1:0] LastReg,
   output logic [ADDR_W-1:0] ReadReg,
   input  logic [DATA_W-1:0] ReadData,
   output logic              DumpValid,
   input  logic              DumpReady,
   output logic [ADDR_W-1:0] DumpAddr,
   output logic [DATA_W-1:0] DumpData,
   output logic              Busy,
   output logic              Done
);

   localparam int CNT_W = ADDR_W + 1;

   dumpState_t        state;
   logic [ADDR_W-1:0] rdPtr;
   logic [CNT_W-1:0]  remaining;
   logic [ADDR_W-1:0] span;
   logic              load;

   // Modular difference makes First > Last wrap and First == Last+1 cover the whole file.
   assign span    = LastReg - FirstReg;
   assign load    = (state == RUN) && (!DumpValid || DumpReady);
   assign ReadReg = rdPtr;
   assign Busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rdPtr     <= '0;
         remaining <= '0;
         Done      <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  rdPtr     <= FirstReg;
                  remaining <= {1'b0, span} + CNT_W'(1);
                  state     <= RUN;
               end
            end
            RUN: begin
               if (load) begin
                  rdPtr     <= rdPtr + ADDR_W'(1);
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (DumpValid && DumpReady) begin
                  Done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   regfile_dump_slot #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .loadAddr(rdPtr),
      .loadData(ReadData),
      .ready   (DumpReady),
      .valid   (DumpValid),
      .addr    (DumpAddr),
      .data    (DumpData)
   );

endmodule

// File: tb/tb_regfile_dumper.sv
// tb/tb_regfile_dumper.sv - scoreboard bench for regfile_dumper against a behavioural register file
module tb_regfile_dumper;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Start = 1'b0;
   logic [4:0]  FirstReg = '0;
   logic [4:0]  LastReg = '0;
   logic [4:0]  ReadReg;
   logic [31:0] ReadData;
   logic        DumpValid;
   logic        DumpReady = 1'b0;
   logic [4:0]  DumpAddr;
   logic [31:0] DumpData;
   logic        Busy;
   logic        Done;

   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [31:0] rf  [NUM_REGS];
   logic [31:0] mdl [NUM_REGS];
   logic [36:0] q [$];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   // Register file: combinational read, write commits on the clock edge.
   always @(posedge clk) if (we) rf[wa] <= wd;
   assign ReadData = rf[ReadReg];

   regfile_dumper dut (
      .clk      (clk),
      .rst      (rst),
      .Start    (Start),
      .FirstReg (FirstReg),
      .LastReg  (LastReg),
      .ReadReg  (ReadReg),
      .ReadData (ReadData),
      .DumpValid(DumpValid),
      .DumpReady(DumpReady),
      .DumpAddr (DumpAddr),
      .DumpData (DumpData),
      .Busy     (Busy),
      .Done     (Done)
   );

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; wa = a; wd = d; mdl[a] = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   // Pushes the expected words, pulses Start, then scores every word until Done.
   // mode 0: ready always high; mode 1: ready 1,0,0,1,0,0...
   // hookKind 1: Start with another range at hookAt; 2: write reg 10 = 0xA5 at hookAt.
   task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                           input int hookAt, input int hookKind,
                           output int doneAt, output int words);
      logic [4:0] span;
      logic [4:0] a;
      int n;
      span = l - f;
      n = int'(span) + 1;
      for (int i = 0; i < n; i++) begin
         a = f + 5'(i);
         q.push_back({a, mdl[a]});
      end
      @(negedge clk);
      FirstReg = f; LastReg = l; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      doneAt = -1;
      words = 0;
      for (int j = 0; j < 300; j++) begin
         Start = 1'b0;
         we = 1'b0;
         if (j == 0) begin
            total++;
            if (Busy !== 1'b1 || ReadReg !== f)
               $display("FAIL startup: Busy=%b ReadReg=%0d required Busy=1 ReadReg=%0d", Busy, ReadReg, f);
            else passed++;
         end
         DumpReady = (mode == 0) ? 1'b1 : (j % 3 == 0);
         if (j == hookAt && hookKind == 1) begin
            FirstReg = 5'd20; LastReg = 5'd25; Start = 1'b1;
         end
         if (j == hookAt && hookKind == 2) begin
            we = 1'b1; wa = 5'd10; wd = 32'hA5; mdl[10] = 32'hA5;
         end
         if (Done === 1'b1) begin
            doneAt = j;
            total++;
            if (Busy !== 1'b0 || DumpValid !== 1'b0)
               $display("FAIL done_cycle: Busy=%b DumpValid=%b required 0/0", Busy, DumpValid);
            else passed++;
            break;
         end
         if (DumpValid === 1'b1) begin
            total++;
            if (q.size() == 0) begin
               $display("FAIL extra_word: addr=%0d data=%h required no word", DumpAddr, DumpData);
            end else if ({DumpAddr, DumpData} !== q[0]) begin
               $display("FAIL word: addr=%0d data=%h required addr=%0d data=%h",
                        DumpAddr, DumpData, q[0][36:32], q[0][31:0]);
            end else passed++;
            if (DumpReady && q.size() != 0) begin
               void'(q.pop_front());
               words++;
            end
         end
         @(negedge clk);
      end
      Start = 1'b0;
      we = 1'b0;
      total++;
      if (doneAt < 0) $display("FAIL done_timeout: no Done within 300 cycles required Done");
      else passed++;
      total++;
      if (q.size() != 0) $display("FAIL missing_words: %0d left required 0", q.size());
      else passed++;
      q.delete();
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++;
      if (ReadReg !== 5'd0 || DumpValid !== 1'b0 || DumpAddr !== 5'd0 || DumpData !== 32'd0 ||
          Busy !== 1'b0 || Done !== 1'b0)
         $display("FAIL reset: ReadReg=%0d V=%b A=%0d D=%h Busy=%b Done=%b required all 0",
                  ReadReg, DumpValid, DumpAddr, DumpData, Busy, Done);
      else passed++;
      rst = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) wr(5'(k), 32'(k * 3));
   endtask

   task automatic test_full_dump;
      int d, w;
      run_dump(5'd0, 5'd31, 0, -1, 0, d, w);
      total++;
      if (d !== 33) $display("FAIL full_done_latency: %0d required 33", d); else passed++;
      total++;
      if (w !== 32) $display("FAIL full_words: %0d required 32", w); else passed++;
   endtask

   task automatic test_backpressure;
      int d, w;
      run_dump(5'd10, 5'd12, 1, -1, 0, d, w);
      total++;
      if (w !== 3) $display("FAIL bp_words: %0d required 3", w); else passed++;
   endtask

   task automatic test_wrap_single;
      int d, w;
      run_dump(5'd30, 5'd1, 0, -1, 0, d, w);
      total++;
      if (w !== 4 || d !== 5) $display("FAIL wrap: words=%0d done=%0d required 4/5", w, d); else passed++;
      wr(5'd12, 32'd12);
      run_dump(5'd12, 5'd12, 0, -1, 0, d, w);
      total++;
      if (w !== 1 || d !== 2) $display("FAIL single: words=%0d done=%0d required 1/2", w, d); else passed++;
   endtask

   task automatic test_reset_mid;
      int d, w;
      for (int i = 0; i < 10; i++) q.push_back({5'(i), mdl[i]});
      @(negedge clk);
      FirstReg = 5'd0; LastReg = 5'd9; Start = 1'b1; DumpReady = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (DumpValid !== 1'b1 || {DumpAddr, DumpData} !== {5'd4, mdl[4]})
         $display("FAIL mid_5th_word: V=%b addr=%0d data=%h required 1/4/%h", DumpValid, DumpAddr, DumpData, mdl[4]);
      else passed++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (DumpValid !== 1'b0 || Busy !== 1'b0 || ReadReg !== 5'd0 || Done !== 1'b0)
         $display("FAIL mid_reset: V=%b Busy=%b ReadReg=%0d Done=%b required 0", DumpValid, Busy, ReadReg, Done);
      else passed++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (Done !== 1'b0 || DumpValid !== 1'b0)
            $display("FAIL mid_quiet: Done=%b V=%b required 0/0", Done, DumpValid);
         else passed++;
      end
      q.delete();
      run_dump(5'd3, 5'd6, 0, -1, 0, d, w);
      total++;
      if (w !== 4 || d !== 5) $display("FAIL after_reset: words=%0d done=%0d required 4/5", w, d); else passed++;
   endtask

   task automatic test_start_busy;
      int d, w;
      run_dump(5'd0, 5'd5, 0, 2, 1, d, w);
      total++;
      if (w !== 6 || d !== 7) $display("FAIL start_busy: words=%0d done=%0d required 6/7", w, d); else passed++;
      @(negedge clk);
      total++;
      if (Busy !== 1'b0 || DumpValid !== 1'b0)
         $display("FAIL start_busy_idle: Busy=%b V=%b required 0/0", Busy, DumpValid);
      else passed++;
   endtask

   task automatic test_concurrent_write;
      int d, w;
      run_dump(5'd10, 5'd10, 0, 0, 2, d, w);
      total++;
      if (w !== 1) $display("FAIL cw_words: %0d required 1", w); else passed++;
      run_dump(5'd10, 5'd10, 0, -1, 0, d, w);
      total++;
      if (mdl[10] !== 32'hA5 || w !== 1) $display("FAIL cw_new: model=%h words=%0d required a5/1", mdl[10], w);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_full_dump();
      test_backpressure();
      test_wrap_single();
      test_reset_mid();
      test_start_busy();
      test_concurrent_write();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
